mips_multicycle_ctrl: RTL and testbench

- Multicycle MIPS control unit: the initiator side of the ALU interface. Issues the 4-bit ALU operation code each cycle and consumes the ALU Zero flag for branches.
- Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type (add, sub, and, or, slt, nor), beq, addi, j.
- Drives all datapath mux selects and write enables of the shared-memory multicycle datapath.

---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 21 ++
 rtl/mips_multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode, funct, ALU-code and state constants for the multicycle MIPS control unit (BNE_EN adds the BRANCHNE state)
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
`ifdef BNE_EN
    localparam logic [3:0] S_BRANCHNE = 4'd12;
`endif

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// alu_decoder: maps an R-type funct field to its ALU operation code and flags unsupported functs
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_valid
);

    // Unsupported functs fall back to ADD; funct_valid lets DECODE turn them into a NOP
    always_comb begin
        alu_control = funct == FN_SUB ? ALU_SUB :
                      funct == FN_AND ? ALU_AND :
                      funct == FN_OR  ? ALU_OR  :
                      funct == FN_SLT ? ALU_SLT :
                      funct == FN_NOR ? ALU_NOR : ALU_ADD;
        funct_valid = funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                      funct == FN_OR  || funct == FN_SLT || funct == FN_NOR;
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore FSM sequencing the shared-memory multicycle MIPS datapath (BNE_EN adds bne)
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUControl,
    output logic [3:0] state_dbg
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] fn_alu;
    logic       funct_valid;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;

    alu_decoder u_alu_decoder (
        .funct      (Funct),
        .alu_control(fn_alu),
        .funct_valid(funct_valid)
    );

    assign state_dbg = state;

    // State register; reset always lands in FETCH so an interrupted instruction is dropped
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Next-state logic; unsupported opcodes/functs and unused encodings return to FETCH
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = funct_valid ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
`ifdef BNE_EN
                    OP_BNE:       next_state = S_BRANCHNE;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = Opcode == OP_LW ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTE:  next_state = S_ALUWB;
            S_ADDIEXEC: next_state = S_ADDIWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Output decode from the registered state; reset masks every enable and select
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = ALU_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = fn_alu;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
`ifdef BNE_EN
            S_BRANCHNE: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch_ne  = 1'b1;
            end
`endif
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB:   RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        PCEn = pc_write | (branch & Zero) | (branch_ne & ~Zero);
        if (reset) begin
            PCEn       = 1'b0;
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            PCSrc      = 2'b00;
            ALUControl = ALU_ADD;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized self-checking bench for mips_multicycle_ctrl (honours BNE_EN)
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl, state_dbg;

    int checks = 0;
    int errors = 0;

    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EX, P_AWB, P_BR, P_BNE, P_AE, P_AI, P_J} phase_t;
    phase_t      seq [5];
    int          seq_len;
    logic [19:0] obs [5];
    logic [19:0] expv [5];

    wire [19:0] outv = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                        ALUSrcB, PCSrc, ALUControl, state_dbg};

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUControl(ALUControl), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic ref_valid(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b101010 || f == 6'b100111;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b0010;
        endcase
    endfunction

    // Instruction -> list of phases it passes through, starting at FETCH
    task automatic plan(input logic [5:0] op, input logic [5:0] fn);
        seq[0] = P_F;
        seq[1] = P_D;
        seq_len = 2;
        case (op)
            6'b100011: begin seq[2] = P_MA; seq[3] = P_MR; seq[4] = P_MWB; seq_len = 5; end
            6'b101011: begin seq[2] = P_MA; seq[3] = P_MW; seq_len = 4; end
            6'b000000: if (ref_valid(fn)) begin seq[2] = P_EX; seq[3] = P_AWB; seq_len = 4; end
            6'b000100: begin seq[2] = P_BR; seq_len = 3; end
            6'b001000: begin seq[2] = P_AE; seq[3] = P_AI; seq_len = 4; end
            6'b000010: begin seq[2] = P_J; seq_len = 3; end
`ifdef BNE_EN
            6'b000101: begin seq[2] = P_BNE; seq_len = 3; end
`endif
            default: ;
        endcase
    endtask

    // Expected output vector for one phase
    function automatic logic [19:0] ref_out(input phase_t p, input logic [5:0] fn, input logic z);
        logic pcen, iord, mw, irw, rd, m2r, rw, sa;
        logic [1:0] sb, ps;
        logic [3:0] alu, st;
        {pcen, iord, mw, irw, rd, m2r, rw, sa} = 8'b0;
        sb = 2'b00;
        ps = 2'b00;
        alu = 4'b0010;
        st = S_FETCH;
        case (p)
            P_F:   begin pcen = 1; irw = 1; sb = 2'b01; st = S_FETCH; end
            P_D:   begin sb = 2'b11; st = S_DECODE; end
            P_MA:  begin sa = 1; sb = 2'b10; st = S_MEMADR; end
            P_MR:  begin iord = 1; st = S_MEMREAD; end
            P_MWB: begin m2r = 1; rw = 1; st = S_MEMWB; end
            P_MW:  begin iord = 1; mw = 1; st = S_MEMWRITE; end
            P_EX:  begin sa = 1; alu = ref_alu(fn); st = S_EXECUTE; end
            P_AWB: begin rd = 1; rw = 1; st = S_ALUWB; end
            P_BR:  begin sa = 1; alu = 4'b0110; ps = 2'b01; pcen = z; st = S_BRANCH; end
`ifdef BNE_EN
            P_BNE: begin sa = 1; alu = 4'b0110; ps = 2'b01; pcen = ~z; st = S_BRANCHNE; end
`endif
            P_AE:  begin sa = 1; sb = 2'b10; st = S_ADDIEXEC; end
            P_AI:  begin rw = 1; st = S_ADDIWB; end
            P_J:   begin pcen = 1; ps = 2'b10; st = S_JUMP; end
            default: ;
        endcase
        return {pcen, iord, mw, irw, rd, m2r, rw, sa, sb, ps, alu, st};
    endfunction

    // Drives one instruction from FETCH and records observed/expected vectors; zmode 0/1 forces Zero, 2 randomizes
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        plan(op, fn);
        Opcode = op;
        Funct = fn;
        for (int i = 0; i < seq_len; i++) begin
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            @(negedge clk);
            obs[i] = outv;
            expv[i] = ref_out(seq[i], fn, Zero);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [19:0] rv;
        reset = 1'b1;
        Opcode = 6'($urandom);
        Funct = 6'($urandom);
        Zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rv = {12'b0, 4'b0010, S_FETCH};
        checks++;
        if (outv !== rv) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", outv, rv);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        int rw_cnt;
        run_instr(6'b100011, 6'($urandom), 2);
        rw_cnt = 0;
        for (int i = 0; i < seq_len; i++) begin
            rw_cnt += int'(obs[i][13]);
            checks++;
            if (obs[i] !== expv[i]) begin
                errors++;
                $display("FAIL lw_cycle%0d got %h want %h", i, obs[i], expv[i]);
            end
        end
        checks++;
        if (rw_cnt != 1 || obs[4][13] !== 1'b1 || obs[4][14] !== 1'b1) begin
            errors++;
            $display("FAIL lw_regwrite_pulse got count %0d last %b want count 1 with MemtoReg", rw_cnt, obs[4][14:13]);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fl [2] = '{6'b100010, 6'b100111};
        logic [3:0] al [2] = '{4'b0110, 4'b1100};
        for (int k = 0; k < 2; k++) begin
            run_instr(6'b000000, fl[k], 2);
            for (int i = 0; i < seq_len; i++) begin
                checks++;
                if (obs[i] !== expv[i]) begin
                    errors++;
                    $display("FAIL rtype%0d_cycle%0d got %h want %h", k, i, obs[i], expv[i]);
                end
            end
            checks++;
            if (seq_len != 4 || obs[2][7:4] !== al[k] || obs[3][15] !== 1'b1 || obs[3][13] !== 1'b1) begin
                errors++;
                $display("FAIL rtype%0d_exec got alu %b wb %b want alu %b wb 11", k, obs[2][7:4], {obs[3][15], obs[3][13]}, al[k]);
            end
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            run_instr(6'b000100, 6'($urandom), z);
            for (int i = 0; i < seq_len; i++) begin
                checks++;
                if (obs[i] !== expv[i]) begin
                    errors++;
                    $display("FAIL beq_z%0d_cycle%0d got %h want %h", z, i, obs[i], expv[i]);
                end
            end
            checks++;
            if (obs[2][19] !== 1'(z) || obs[2][9:8] !== 2'b01 || obs[2][7:4] !== 4'b0110) begin
                errors++;
                $display("FAIL beq_z%0d_branch got pcen %b pcsrc %b alu %b want %0d 01 0110", z, obs[2][19], obs[2][9:8], obs[2][7:4], z);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ol [2] = '{6'b111111, 6'b000000};
        for (int k = 0; k < 2; k++) begin
            run_instr(ol[k], 6'b000000, 2);
            for (int i = 0; i < seq_len; i++) begin
                checks++;
                if (obs[i] !== expv[i] || obs[i][17] !== 1'b0 || obs[i][13] !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal%0d_cycle%0d got %h want %h", k, i, obs[i], expv[i]);
                end
            end
        end
        checks++;
        if (state_dbg !== S_FETCH) begin
            errors++;
            $display("FAIL illegal_return got state %0d want %0d", state_dbg, S_FETCH);
        end
    endtask

    task automatic test_sw_j();
        run_instr(6'b101011, 6'($urandom), 2);
        for (int i = 0; i < seq_len; i++) begin
            checks++;
            if (obs[i] !== expv[i]) begin
                errors++;
                $display("FAIL sw_cycle%0d got %h want %h", i, obs[i], expv[i]);
            end
        end
        checks++;
        if (obs[3][18:17] !== 2'b11 || obs[2][17] !== 1'b0) begin
            errors++;
            $display("FAIL sw_memwrite got iord/memwrite %b want 11", obs[3][18:17]);
        end
        run_instr(6'b000010, 6'($urandom), 2);
        for (int i = 0; i < seq_len; i++) begin
            checks++;
            if (obs[i] !== expv[i]) begin
                errors++;
                $display("FAIL j_cycle%0d got %h want %h", i, obs[i], expv[i]);
            end
        end
        checks++;
        if (obs[2][19] !== 1'b1 || obs[2][9:8] !== 2'b10) begin
            errors++;
            $display("FAIL j_pc got pcen %b pcsrc %b want 1 10", obs[2][19], obs[2][9:8]);
        end
    endtask

    task automatic test_bne();
        run_instr(6'b000101, 6'($urandom), 0);
        for (int i = 0; i < seq_len; i++) begin
            checks++;
            if (obs[i] !== expv[i]) begin
                errors++;
                $display("FAIL bne_cycle%0d got %h want %h", i, obs[i], expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        Opcode = 6'b000000;
        Funct = 6'b100000;
        Zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state_dbg !== S_EXECUTE) begin
            errors++;
            $display("FAIL midreset_setup got state %0d want %0d", state_dbg, S_EXECUTE);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({PCEn, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
                errors++;
                $display("FAIL midreset_enables%0d got %b want 0000", i, {PCEn, MemWrite, IRWrite, RegWrite});
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== S_FETCH || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release got state %0d regwrite %b want %0d 0", state_dbg, RegWrite, S_FETCH);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                                6'b000010, 6'b000101, 6'b111111, 6'b000000};
        logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        logic [5:0] op, fn;
        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            fn = $urandom_range(0, 1) ? fns[$urandom_range(0, 5)] : 6'($urandom);
            run_instr(op, fn, 2);
            for (int i = 0; i < seq_len; i++) begin
                checks++;
                if (obs[i] !== expv[i]) begin
                    errors++;
                    $display("FAIL rand%0d_op%b_fn%b_cycle%0d got %h want %h", n, op, fn, i, obs[i], expv[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_illegal();
        test_sw_j();
        test_bne();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
